// File: rtl/divider_sequential.sv
// Restoring sequential divider: one quotient bit per clock behind a valid/ready handshake.
// Define DIVIDER_SIGNED_EN to add the signed_op port for two's-complement division.
module divider_sequential #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid_in,
    output logic             ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             valid_out,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;
    logic             r_negQ;
    logic             r_negR;

    logic [WIDTH:0]   w_shift;
    logic             w_qbit;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_qNew;
    logic [WIDTH-1:0] w_qFinal;
    logic [WIDTH-1:0] w_rFinal;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;
    logic             w_negQ;
    logic             w_negR;

    // Signed requests are divided as magnitudes; the result signs are remembered for the final load.
`ifdef DIVIDER_SIGNED_EN
    logic w_aNeg;
    logic w_bNeg;
    assign w_aNeg = signed_op & a[WIDTH-1];
    assign w_bNeg = signed_op & b[WIDTH-1];
    assign w_aMag = w_aNeg ? -a : a;
    assign w_bMag = w_bNeg ? -b : b;
    assign w_negQ = (w_aNeg ^ w_bNeg) & (b != '0);
    assign w_negR = w_aNeg;
`else
    assign w_aMag = a;
    assign w_bMag = b;
    assign w_negQ = 1'b0;
    assign w_negR = 1'b0;
`endif

    // The shifted remainder is always below 2*divisor, so the low WIDTH bits of the difference suffice.
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_qbit    = (w_shift >= {1'b0, r_div});
    assign w_remNext = w_qbit ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
    assign w_qNew    = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_qFinal  = r_negQ ? -w_qNew : w_qNew;
    assign w_rFinal  = r_negR ? -w_remNext : w_remNext;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (valid_in) w_nextState = RUN;
            RUN:     if (r_count == LAST_ITER) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
            r_negQ  <= 1'b0;
            r_negR  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_count <= '0;
                        r_rem   <= '0;
                        r_dvd   <= w_aMag;
                        r_div   <= w_bMag;
                        r_negQ  <= w_negQ;
                        r_negR  <= w_negR;
                    end
                end
                RUN: begin
                    r_rem   <= w_remNext;
                    r_dvd   <= w_qNew;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_ITER) begin
                        r_q   <= w_qFinal;
                        r_r   <= w_rFinal;
                        r_dbz <= (r_div == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready       = (r_state == IDLE);
    assign valid_out   = (r_state == DONE);
    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_sequential.sv
// Self-checking bench for divider_sequential: arithmetic reference model plus directed and random stimulus.
// Build with DIVIDER_SIGNED_EN defined to also exercise the signed_op port.
module tb_divider_sequential;

    localparam int W = 32;
`ifdef DIVIDER_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         validIn;
    logic         signedOp;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         ready;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         validOut;
    logic         divByZero;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    divider_sequential #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef DIVIDER_SIGNED_EN
        .signed_op  (signedOp),
`endif
        .a          (opA),
        .b          (opB),
        .valid_in   (validIn),
        .ready      (ready),
        .q          (q),
        .r          (r),
        .valid_out  (validOut),
        .div_by_zero(divByZero)
    );

    function automatic void checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endfunction

    // Reference arithmetic: plain division with the divide-by-zero and signed overflow conventions.
    function automatic void refDivide(input logic [W-1:0] x, input logic [W-1:0] y, input logic sop,
                                      output logic [W-1:0] qq, output logic [W-1:0] rr, output logic zz);
        zz = (y == 0);
        if (y == 0) begin
            qq = '1;
            rr = x;
        end else if (sop && SIGNED_BUILD) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                qq = 32'h8000_0000;
                rr = '0;
            end else begin
                qq = $signed(x) / $signed(y);
                rr = $signed(x) % $signed(y);
            end
        end else begin
            qq = x / y;
            rr = x % y;
        end
    endfunction

    // Transaction-level timing model: a request accepted at edge k completes at edge k+W.
    int           edgeN    = 0;
    int           nextFree = 0;
    int           doneEdge = -1;
    bit           pending  = 1'b0;
    logic [W-1:0] pendQ, pendR;
    logic         pendZ;
    logic [W-1:0] expQ = '0;
    logic [W-1:0] expR = '0;
    logic         expZ = 1'b0;
    logic         expValid = 1'b0;
    logic         expReady = 1'b1;

    always @(posedge clk) begin
        edgeN++;
        expValid = 1'b0;
        if (reset) begin
            pending  = 1'b0;
            nextFree = edgeN + 1;
            expQ     = '0;
            expR     = '0;
            expZ     = 1'b0;
        end else begin
            if (pending && edgeN == doneEdge) begin
                expQ     = pendQ;
                expR     = pendR;
                expZ     = pendZ;
                expValid = 1'b1;
                pending  = 1'b0;
            end
            if (validIn && edgeN >= nextFree) begin
                refDivide(opA, opB, signedOp, pendQ, pendR, pendZ);
                pending  = 1'b1;
                doneEdge = edgeN + W;
                nextFree = edgeN + W + 2;
            end
        end
        expReady = (edgeN + 1 >= nextFree);
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cmp.ready", {63'b0, ready}, {63'b0, expReady});
            checkOutput("cmp.valid_out", {63'b0, validOut}, {63'b0, expValid});
            checkOutput("cmp.q", {32'b0, q}, {32'b0, expQ});
            checkOutput("cmp.r", {32'b0, r}, {32'b0, expR});
            checkOutput("cmp.div_by_zero", {63'b0, divByZero}, {63'b0, expZ});
        end
    end

    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic sop);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) checkOutput("readyWait", 64'd0, 64'd1);
        validIn  = 1'b1;
        opA      = ta;
        opB      = tbv;
        signedOp = sop;
        @(negedge clk);
        validIn  = 1'b0;
    endtask

    task automatic awaitResult(input int start, output int lat);
        lat = start;
        while (!validOut && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!validOut) checkOutput("doneTimeout", 64'd0, 64'd1);
    endtask

    task automatic runDirected(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic sop,
                               input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int lat;
        applyStimulus(ta, tbv, sop);
        awaitResult(1, lat);
        checkOutput({nm, ".latency"}, 64'(lat), 64'(W + 1));
        checkOutput({nm, ".q"}, {32'b0, q}, {32'b0, eq});
        checkOutput({nm, ".r"}, {32'b0, r}, {32'b0, er});
        checkOutput({nm, ".dbz"}, {63'b0, divByZero}, {63'b0, ez});
        @(negedge clk);
        checkOutput({nm, ".validDrop"}, {63'b0, validOut}, 64'd0);
        checkOutput({nm, ".readyBack"}, {63'b0, ready}, 64'd1);
        checkOutput({nm, ".qHeld"}, {32'b0, q}, {32'b0, eq});
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'($urandom_range(1, 15));
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int lat;
        int pulses;
        logic [W-1:0] mq, mr;
        logic mz;
        logic [W-1:0] sx, sy;

        reset    = 1'b1;
        validIn  = 1'b0;
        signedOp = 1'b0;
        opA      = '0;
        opB      = '0;

        refDivide(32'd100, 32'd7, 1'b0, mq, mr, mz);
        checkOutput("model.100div7.q", {32'b0, mq}, 64'd14);
        checkOutput("model.100div7.r", {32'b0, mr}, 64'd2);
        refDivide(32'h1234, 32'd0, 1'b0, mq, mr, mz);
        checkOutput("model.div0.q", {32'b0, mq}, 64'hFFFF_FFFF);
        checkOutput("model.div0.z", {63'b0, mz}, 64'd1);

        repeat (2) @(negedge clk);
        checkOutput("reset.ready", {63'b0, ready}, 64'd1);
        checkOutput("reset.valid_out", {63'b0, validOut}, 64'd0);
        checkOutput("reset.q", {32'b0, q}, 64'd0);
        checkOutput("reset.r", {32'b0, r}, 64'd0);
        checkOutput("reset.dbz", {63'b0, divByZero}, 64'd0);
        checkEn = 1'b1;
        reset   = 1'b0;
        @(negedge clk);

        runDirected("basic", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        runDirected("divZero", 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        runDirected("maxByOne", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        runDirected("aLessB", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
        runDirected("aEqB", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd1, 32'd0, 1'b0);

        // A second request while busy must be dropped, not queued.
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        validIn = 1'b1;
        opA     = 32'd50;
        opB     = 32'd5;
        @(negedge clk);
        validIn = 1'b0;
        awaitResult(11, lat);
        checkOutput("busy.latency", 64'(lat), 64'(W + 1));
        checkOutput("busy.q", {32'b0, q}, 64'd14);
        checkOutput("busy.r", {32'b0, r}, 64'd2);
        @(negedge clk);

        // Reset in the middle of a division discards it.
        applyStimulus(32'd20, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midReset.valid_out", {63'b0, validOut}, 64'd0);
        checkOutput("midReset.q", {32'b0, q}, 64'd0);
        checkOutput("midReset.r", {32'b0, r}, 64'd0);
        checkOutput("midReset.dbz", {63'b0, divByZero}, 64'd0);
        checkOutput("midReset.ready", {63'b0, ready}, 64'd1);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (validOut) pulses++;
        end
        checkOutput("midReset.noPulse", 64'(pulses), 64'd0);

`ifdef DIVIDER_SIGNED_EN
        runDirected("sNeg7by2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        runDirected("s7byNeg2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        runDirected("sOverflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        runDirected("sDivZero", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        runDirected("sOpOff", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

        // Random traffic, including requests that arrive while busy.
        repeat (1500) begin
            validIn  = ($urandom_range(0, 3) == 0);
            opA      = pickOperand();
            opB      = ($urandom_range(0, 7) == 0) ? opA : pickOperand();
            signedOp = SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        validIn  = 1'b0;
        signedOp = 1'b0;
        repeat (W + 4) @(negedge clk);

        // Back-to-back sweep with the division identity as the check.
        sx = 32'h2345_6789;
        sy = 32'h3456_7891;
        for (int i = 0; i < 100; i++) begin
            logic ok;
            applyStimulus(sx, sy, 1'b0);
            awaitResult(1, lat);
            ok = (({32'b0, q} * {32'b0, sy} + {32'b0, r}) == {32'b0, sx}) && (r < sy);
            checkOutput("sweep.identity", {63'b0, ok}, 64'd1);
            if (!ok) begin
                $display("[TB] FAIL sweep step %0d: a=%0h b=%0h q=%0h r=%0h", i, sx, sy, q, r);
                $fatal(1, "[TB] sweep identity violated");
            end
            sx = sx + 32'h2345_6789;
            sy = sy + 32'h3456_7891;
        end
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/divider_sequential.md
Name: divider_sequential

Overview:
- Iterative unsigned integer divider; inverse operation of the team's pipelined multiplier.
- Computes quotient and remainder of a / b, one quotient bit per clock (restoring algorithm).
- Sits beside the multiplier in the functional-units area, behind a valid/ready handshake so a core or bench can issue one division at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; latency scales as WIDTH+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- a  input  WIDTH  dividend, sampled only at acceptance
- b  input  WIDTH  divisor, sampled only at acceptance
- valid_in  input  1  request; accepted on an edge where valid_in=1 and ready=1
- ready  output  1  high only in IDLE; divider can accept a request
- q  output  WIDTH  quotient, held until next result
- r  output  WIDTH  remainder, held until next result
- valid_out  output  1  one-cycle pulse marking q/r/div_by_zero valid
- div_by_zero  output  1  result was produced with b==0; held with q/r

Behaviour:
- Reset (synchronous, any state, including mid-operation): state=IDLE, ready=1, valid_out=0, q=0, r=0, div_by_zero=0, iteration counter=0. An in-flight division is discarded and never pulses valid_out.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: ready=1. On an edge with valid_in=1, latch a, b; clear the partial remainder; counter=0; go to RUN. Acceptance is edge E0.
- RUN: ready=0. Each edge: shift {rem, dividend} left 1; trial = rem - b (WIDTH+1 bits). If trial is non-negative, rem=trial and the quotient bit is 1; otherwise rem is unchanged and the bit is 0. Counter increments. The WIDTH-th iteration occurs at edge E_WIDTH (E32 by default).
- At E_WIDTH: load q, r, div_by_zero=(latched b==0); set valid_out=1; go to DONE.
- DONE: lasts exactly one cycle with valid_out=1 and ready=0. The next edge clears valid_out and returns to IDLE, so ready=1 after E_WIDTH+1.
- Latency: valid_out is high in the cycle following edge E0+WIDTH. Throughput is one division per WIDTH+2 cycles.
- valid_in while ready=0 is ignored; the request is not queued. a and b changes after E0 have no effect.
- b==0: no special path. The algorithm naturally yields q=all ones and r=a, with div_by_zero=1. Latency is unchanged.
- a<b: q=0, r=a. a==b (nonzero): q=1, r=0.
- Invariant for b!=0: a == q*b + r and r < b, all unsigned.
- q, r and div_by_zero keep their values after valid_out drops, until the next completion or reset.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: adds input port signed_op (1 bit, sampled at acceptance).
  - When signed_op=1, operands are two's complement. Magnitudes are divided unsigned; then the quotient is negated if the operand signs differ, and the remainder takes the sign of a (truncation toward zero).
  - b==0: q=all ones, r=a, div_by_zero=1.
  - Overflow case (a=most-negative, b=-1): q=most-negative, r=0.
  - Sign fix-up is absorbed into the DONE load, so latency is identical to unsigned.
  - signed_op=0 behaves exactly as the unsigned block.
- Undefined: no signed_op port; unsigned only.

Test Plan:
- Basic: a=100, b=7 accepted at E0 -> valid_out exactly one cycle after E32, q=14, r=2, div_by_zero=0; ready=1 again from the following cycle.
- Divide-by-zero: a=0x00001234, b=0 -> q=0xFFFFFFFF, r=0x00001234, div_by_zero=1, same 33-cycle latency.
- Edges: a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0. a=5, b=9 -> q=0, r=5. a=b=0x80000000 -> q=1, r=0.
- Busy and reset:
  - Pulse valid_in with a=50, b=5 at E10 of a running 100/7 -> ignored; the result is still 14 r 2.
  - Assert reset at E15 of a division -> no valid_out, all outputs 0, ready=1 the next cycle.
- Sweep: 100 back-to-back divisions, a+=0x23456789 and b+=0x34567891 per step (start a=0x23456789, b=0x34567891). Each result must satisfy a==q*b+r with r<b; otherwise $fatal.
- DIVIDER_SIGNED_EN: signed -7/2 -> q=-3, r=-1. 7/-2 -> q=-3, r=1. 0x80000000/-1 -> q=0x80000000, r=0.
